// File: rtl/dmem_arbiter_if.sv
// Signal bundle around dmem_arbiter: MEM-stage port, external word port and the RAM macro port.
// The slave view belongs to the arbiter; the master view is the surrounding pipeline/loader/RAM.
interface dmem_arbiter_if #(
    parameter int unsigned DM_MEM_DEPTH = 4096,
    parameter int unsigned DATA_WIDTH   = 32
);
    localparam int unsigned ADDR_WIDTH = $clog2(DM_MEM_DEPTH);

    // MEM-stage side
    logic                  cpu_mem_read;
    logic                  cpu_mem_write;
    logic [2:0]            cpu_func3;
    logic [31:0]           cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_ready;
    logic                  cpu_misaligned;

    // External loader / debug DMA side
    logic                  ext_req;
    logic                  ext_we;
    logic [ADDR_WIDTH-1:0] ext_addr;
    logic [DATA_WIDTH-1:0] ext_wdata;
    logic                  ext_gnt;
    logic                  ext_ack;
    logic [DATA_WIDTH-1:0] ext_rdata;

    // RAM macro side
    logic                  mem_en;
    logic                  mem_we;
    logic [3:0]            mem_be;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  cpu_mem_read, cpu_mem_write, cpu_func3, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_ready, cpu_misaligned,
        input  ext_req, ext_we, ext_addr, ext_wdata,
        output ext_gnt, ext_ack, ext_rdata,
        output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output cpu_mem_read, cpu_mem_write, cpu_func3, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_ready, cpu_misaligned,
        output ext_req, ext_we, ext_addr, ext_wdata,
        input  ext_gnt, ext_ack, ext_rdata,
        input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the MEM stage and an external word port.
// Round-robin arbitration, RV32I byte/half/word lane mapping, load extension and MEM-stage stall.
module dmem_arbiter #(
    parameter int unsigned DM_MEM_DEPTH = 4096,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned MEM_LATENCY  = 2
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);
    localparam int unsigned ADDR_WIDTH = $clog2(DM_MEM_DEPTH);
    localparam int unsigned CNT_WIDTH  = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD = CNT_WIDTH'(MEM_LATENCY);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } arbState_e;

    typedef enum logic {
        OwnerCpu,
        OwnerExt
    } owner_e;

    // Registered state
    arbState_e             state;
    owner_e                owner;
    owner_e                lastOwner;
    logic                  isWrite;
    logic [2:0]            func3Q;
    logic [1:0]            laneQ;
    logic [CNT_WIDTH-1:0]  latCnt;
    logic                  memEn;
    logic                  memWe;
    logic [3:0]            memBe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memWdata;
    logic                  extGnt;
    logic                  extAck;
    logic                  cpuMisaligned;
    logic [DATA_WIDTH-1:0] cpuRdata;
    logic [DATA_WIDTH-1:0] extRdata;

    // Next-state values
    arbState_e             stateNext;
    owner_e                ownerNext;
    owner_e                lastOwnerNext;
    logic                  isWriteNext;
    logic [2:0]            func3Next;
    logic [1:0]            laneNext;
    logic [CNT_WIDTH-1:0]  latCntNext;
    logic                  memEnNext;
    logic                  memWeNext;
    logic [3:0]            memBeNext;
    logic [ADDR_WIDTH-1:0] memAddrNext;
    logic [DATA_WIDTH-1:0] memWdataNext;
    logic                  extGntNext;
    logic                  extAckNext;
    logic                  cpuMisalignedNext;
    logic [DATA_WIDTH-1:0] cpuRdataNext;
    logic [DATA_WIDTH-1:0] extRdataNext;

    // Request decode
    logic                  cpuReq;
    logic                  cpuWr;
    logic [1:0]            cpuOff;
    logic                  cpuBad;
    logic [3:0]            cpuBe;
    logic [DATA_WIDTH-1:0] cpuLaneData;
    logic                  grantCpu;
    logic                  grantExt;

    // Load extension
    logic [7:0]            rdByte;
    logic [15:0]           rdHalf;
    logic [DATA_WIDTH-1:0] loadExt;

    // Address bits above the RAM depth wrap and are deliberately dropped
    logic unusedAddrBits;
    assign unusedAddrBits = ^bus.cpu_addr[31:ADDR_WIDTH+2];

    assign cpuReq = bus.cpu_mem_read | bus.cpu_mem_write;
    assign cpuWr  = bus.cpu_mem_write;
    assign cpuOff = bus.cpu_addr[1:0];

    // Misaligned halves/words and undefined or store-unsigned funct3 are rejected
    always_comb begin
        case (bus.cpu_func3)
            3'b000:  cpuBad = 1'b0;
            3'b100:  cpuBad = cpuWr;
            3'b001:  cpuBad = cpuOff[0];
            3'b101:  cpuBad = cpuWr | cpuOff[0];
            3'b010:  cpuBad = |cpuOff;
            default: cpuBad = 1'b1;
        endcase
    end

    // Store lane mapping; loads always read the full word
    always_comb begin
        cpuBe       = 4'b1111;
        cpuLaneData = bus.cpu_wdata;
        if (cpuWr) begin
            case (bus.cpu_func3[1:0])
                2'b00: begin
                    cpuBe       = 4'b0001 << cpuOff;
                    cpuLaneData = {4{bus.cpu_wdata[7:0]}};
                end
                2'b01: begin
                    cpuBe       = cpuOff[1] ? 4'b1100 : 4'b0011;
                    cpuLaneData = {2{bus.cpu_wdata[15:0]}};
                end
                default: ;
            endcase
        end
    end

    // Round robin: on a tie the side not served last wins
    assign grantCpu = cpuReq & (~bus.ext_req | (lastOwner == OwnerExt));
    assign grantExt = bus.ext_req & ~grantCpu;

    always_comb begin
        rdByte = bus.mem_rdata[7:0];
        case (laneQ)
            2'd1:    rdByte = bus.mem_rdata[15:8];
            2'd2:    rdByte = bus.mem_rdata[23:16];
            2'd3:    rdByte = bus.mem_rdata[31:24];
            default: ;
        endcase
        rdHalf = laneQ[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
        case (func3Q)
            3'b000:  loadExt = {{24{rdByte[7]}}, rdByte};
            3'b100:  loadExt = {24'h0, rdByte};
            3'b001:  loadExt = {{16{rdHalf[15]}}, rdHalf};
            3'b101:  loadExt = {16'h0, rdHalf};
            default: loadExt = bus.mem_rdata;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        stateNext         = state;
        ownerNext         = owner;
        lastOwnerNext     = lastOwner;
        isWriteNext       = isWrite;
        func3Next         = func3Q;
        laneNext          = laneQ;
        latCntNext        = latCnt;
        memEnNext         = 1'b0;
        memWeNext         = 1'b0;
        memBeNext         = memBe;
        memAddrNext       = memAddr;
        memWdataNext      = memWdata;
        cpuMisalignedNext = 1'b0;
        cpuRdataNext      = cpuRdata;
        extRdataNext      = extRdata;

        case (state)
            StIdle: begin
                if (grantCpu) begin
                    ownerNext     = OwnerCpu;
                    lastOwnerNext = OwnerCpu;
                    isWriteNext   = cpuWr;
                    func3Next     = bus.cpu_func3;
                    laneNext      = cpuOff;
                    if (cpuBad) begin
                        stateNext         = StDone;
                        cpuMisalignedNext = 1'b1;
                        cpuRdataNext      = '0;
                    end else begin
                        stateNext    = StIssue;
                        memEnNext    = 1'b1;
                        memWeNext    = cpuWr;
                        memBeNext    = cpuBe;
                        memAddrNext  = bus.cpu_addr[ADDR_WIDTH+1:2];
                        memWdataNext = cpuLaneData;
                    end
                end else if (grantExt) begin
                    ownerNext     = OwnerExt;
                    lastOwnerNext = OwnerExt;
                    isWriteNext   = bus.ext_we;
                    stateNext     = StIssue;
                    memEnNext     = 1'b1;
                    memWeNext     = bus.ext_we;
                    memBeNext     = 4'b1111;
                    memAddrNext   = bus.ext_addr;
                    memWdataNext  = bus.ext_wdata;
                end
            end
            StIssue: begin
                if (isWrite) begin
                    stateNext = StDone;
                end else begin
                    stateNext  = StWait;
                    latCntNext = CNT_LOAD;
                end
            end
            StWait: begin
                if (latCnt == CNT_LAST) begin
                    stateNext = StDone;
                    if (owner == OwnerCpu) begin
                        cpuRdataNext = loadExt;
                    end else begin
                        extRdataNext = bus.mem_rdata;
                    end
                end else begin
                    latCntNext = latCnt - CNT_LAST;
                end
            end
            StDone: begin
                stateNext = StIdle;
            end
            default: begin
                stateNext = StIdle;
            end
        endcase

        extGntNext = (stateNext != StIdle) && (ownerNext == OwnerExt);
        extAckNext = (stateNext == StDone) && (ownerNext == OwnerExt);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= StIdle;
            owner         <= OwnerCpu;
            lastOwner     <= OwnerExt;
            isWrite       <= 1'b0;
            func3Q        <= 3'b000;
            laneQ         <= 2'b00;
            latCnt        <= '0;
            memEn         <= 1'b0;
            memWe         <= 1'b0;
            memBe         <= 4'b0000;
            memAddr       <= '0;
            memWdata      <= '0;
            extGnt        <= 1'b0;
            extAck        <= 1'b0;
            cpuMisaligned <= 1'b0;
            cpuRdata      <= '0;
            extRdata      <= '0;
        end else begin
            state         <= stateNext;
            owner         <= ownerNext;
            lastOwner     <= lastOwnerNext;
            isWrite       <= isWriteNext;
            func3Q        <= func3Next;
            laneQ         <= laneNext;
            latCnt        <= latCntNext;
            memEn         <= memEnNext;
            memWe         <= memWeNext;
            memBe         <= memBeNext;
            memAddr       <= memAddrNext;
            memWdata      <= memWdataNext;
            extGnt        <= extGntNext;
            extAck        <= extAckNext;
            cpuMisaligned <= cpuMisalignedNext;
            cpuRdata      <= cpuRdataNext;
            extRdata      <= extRdataNext;
        end
    end

    // Stall release is combinational so the hazard unit sees it in the completing cycle
    assign bus.cpu_ready = ~rst & (~cpuReq | ((state == StDone) && (owner == OwnerCpu)));

    assign bus.cpu_rdata      = cpuRdata;
    assign bus.cpu_misaligned = cpuMisaligned;
    assign bus.ext_gnt        = extGnt;
    assign bus.ext_ack        = extAck;
    assign bus.ext_rdata      = extRdata;
    assign bus.mem_en         = memEn;
    assign bus.mem_we         = memWe;
    assign bus.mem_be         = memBe;
    assign bus.mem_addr       = memAddr;
    assign bus.mem_wdata      = memWdata;
endmodule
